// File: rtl/relu.sv
// Purpose : registered rectified-linear activation for signed fixed-point samples.
// Latency : 1 clk (dn_data at edge N+1 reflects up_data/bypass sampled at edge N).
// Backpr. : none; free-running, accepts and emits one sample every cycle.
//
// Optional bounded-ReLU clamp is enabled by defining RELU_CLIP_EN. When it is
// undefined no clamp logic exists and CLIP_VALUE only feeds the config check.
module relu #(
    parameter int                    NUM_WIDTH  = 16,
    parameter int                    FRAC_WIDTH = 8,
    parameter logic signed [15:0]    CLIP_VALUE = 16'sh0600
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        bypass,
    input  logic signed [NUM_WIDTH-1:0] up_data,
    output logic signed [NUM_WIDTH-1:0] dn_data
);

    localparam int MSB = NUM_WIDTH - 1;

    // Reject configurations where the format or clip ceiling make no sense:
    // the fraction must leave at least a sign bit, and the ceiling is positive.
    if (FRAC_WIDTH >= NUM_WIDTH || FRAC_WIDTH < 0 || CLIP_VALUE <= 0) begin : g_bad_cfg
        $error("relu: invalid NUM_WIDTH/FRAC_WIDTH/CLIP_VALUE combination");
    end

`ifdef RELU_CLIP_EN
    // Ceiling resized to the datapath width; sign-extension keeps it exact
    // for any NUM_WIDTH that can hold it.
    localparam logic signed [NUM_WIDTH-1:0] CLIP_W = NUM_WIDTH'(CLIP_VALUE);
`endif

    logic signed [NUM_WIDTH-1:0] dn_data_d;
    logic signed [NUM_WIDTH-1:0] dn_data_q;

    // Next output: raw on bypass, else zero for negatives (sign bit only,
    // no arithmetic), optionally clamped to the ceiling for large positives.
    always_comb begin
        dn_data_d = up_data;
        if (!bypass) begin
            if (up_data[MSB]) begin
                dn_data_d = '0;
            end
`ifdef RELU_CLIP_EN
            else if (up_data > CLIP_W) begin
                dn_data_d = CLIP_W;
            end
`endif
        end
    end

    // Single output register; reset clears it immediately, dropping any
    // sample that was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dn_data_q <= '0;
        end else begin
            dn_data_q <= dn_data_d;
        end
    end

    assign dn_data = dn_data_q;

endmodule

// File: tb/tb_relu.sv
module tb_relu;

    localparam int NW = 16;
`ifdef RELU_CLIP_EN
    localparam int          CLIP_INT  = 1536;
    localparam logic [15:0] CLIP_BITS = 16'h0600;
`endif

    logic          clk;
    logic          rst_n;
    logic          bypass;
    logic [NW-1:0] up_data;
    logic [NW-1:0] dn_data;

    int checks;
    int errors;

    relu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bypass  (bypass),
        .up_data (up_data),
        .dn_data (dn_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference: rectified linear unit evaluated on the integer value.
    function automatic logic [15:0] ref_relu(input bit byp, input logic [15:0] d);
        int v;
        v = int'($signed(d));
        if (byp) return d;
        if (v < 0) return 16'h0000;
`ifdef RELU_CLIP_EN
        if (v > CLIP_INT) return CLIP_BITS;
`endif
        return d;
    endfunction

    // Present one sample mid-cycle and wait until just after it is captured.
    task automatic apply(input bit b, input logic [15:0] d);
        @(negedge clk);
        bypass  = b;
        up_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bypass  = 1'b0;
        up_data = 16'h0500;
        #2;
        checks++;
        if (dn_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", dn_data, 16'h0000);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (dn_data !== 16'h0000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, dn_data, 16'h0000);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (dn_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_release_pre_edge: got %h want %h", dn_data, 16'h0000);
        end
        @(posedge clk);
        #1;
        checks++;
        if (dn_data !== 16'h0500) begin
            errors++;
            $display("FAIL reset_first_sample: got %h want %h", dn_data, 16'h0500);
        end
    endtask

    task automatic test_negative();
        logic [15:0] ins [2];
        ins[0] = 16'hF580;
        ins[1] = 16'hF680;
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, ins[i]);
            checks++;
            if (dn_data !== 16'h0000) begin
                errors++;
                $display("FAIL negative[%0d] in=%h: got %h want %h", i, ins[i], dn_data, 16'h0000);
            end
        end
    endtask

    task automatic test_bypass();
        apply(1'b1, 16'hF780);
        checks++;
        if (dn_data !== 16'hF780) begin
            errors++;
            $display("FAIL bypass_neg0: got %h want %h", dn_data, 16'hF780);
        end
        apply(1'b1, 16'hF880);
        checks++;
        if (dn_data !== 16'hF880) begin
            errors++;
            $display("FAIL bypass_neg1: got %h want %h", dn_data, 16'hF880);
        end
        apply(1'b0, 16'hF980);
        checks++;
        if (dn_data !== 16'h0000) begin
            errors++;
            $display("FAIL bypass_drop: got %h want %h", dn_data, 16'h0000);
        end
`ifdef RELU_CLIP_EN
        apply(1'b1, 16'h7FFF);
        checks++;
        if (dn_data !== 16'h7FFF) begin
            errors++;
            $display("FAIL bypass_no_clip: got %h want %h", dn_data, 16'h7FFF);
        end
`endif
    endtask

    // Ramp from -6.5 in 1.0 steps, checking the output holds until the edge
    // and then reflects the new sample; an async reset pulse lands mid-ramp.
    task automatic test_ramp();
        logic [15:0] prev_exp;
        logic [15:0] exp;
        logic [15:0] d;
        int          v;
        prev_exp = dn_data;
        for (int k = 0; k < 21; k++) begin
            v = -1664 + 256 * k;
            d = v[15:0];
            @(negedge clk);
            bypass  = 1'b0;
            up_data = d;
            #1;
            checks++;
            if (dn_data !== prev_exp) begin
                errors++;
                $display("FAIL ramp_hold[%0d]: got %h want %h", k, dn_data, prev_exp);
            end
            @(posedge clk);
            #1;
            exp = ref_relu(1'b0, d);
            checks++;
            if (dn_data !== exp) begin
                errors++;
                $display("FAIL ramp[%0d] in=%h: got %h want %h", k, d, dn_data, exp);
            end
            prev_exp = exp;
            if (k == 12) begin
                #2;
                rst_n = 1'b0;
                #1;
                checks++;
                if (dn_data !== 16'h0000) begin
                    errors++;
                    $display("FAIL ramp_async_reset: got %h want %h", dn_data, 16'h0000);
                end
                rst_n    = 1'b1;
                prev_exp = 16'h0000;
            end
        end
    endtask

    task automatic test_extremes();
        logic [15:0] ins [3];
        logic [15:0] exp [3];
        ins[0] = 16'h8000; exp[0] = 16'h0000;
`ifdef RELU_CLIP_EN
        ins[1] = 16'h7FFF; exp[1] = 16'h0600;
`else
        ins[1] = 16'h7FFF; exp[1] = 16'h7FFF;
`endif
        ins[2] = 16'h0000; exp[2] = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, ins[i]);
            checks++;
            if (dn_data !== exp[i]) begin
                errors++;
                $display("FAIL extreme[%0d] in=%h: got %h want %h", i, ins[i], dn_data, exp[i]);
            end
        end
        apply(1'b0, 16'hFFFF);
        checks++;
        if (dn_data !== 16'h0000) begin
            errors++;
            $display("FAIL extreme_minus_lsb: got %h want %h", dn_data, 16'h0000);
        end
`ifdef RELU_CLIP_EN
        apply(1'b0, 16'h0600);
        checks++;
        if (dn_data !== 16'h0600) begin
            errors++;
            $display("FAIL clip_at_ceiling: got %h want %h", dn_data, 16'h0600);
        end
        apply(1'b0, 16'h0601);
        checks++;
        if (dn_data !== 16'h0600) begin
            errors++;
            $display("FAIL clip_above_ceiling: got %h want %h", dn_data, 16'h0600);
        end
`endif
    endtask

    // Random back-to-back samples with per-cycle bypass toggling, biased
    // toward the sign/ceiling boundaries.
    task automatic test_random();
        logic [15:0] d;
        logic [15:0] exp;
        bit          b;
        for (int i = 0; i < 300; i++) begin
            b = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0: d = 16'h8000 + 16'($urandom_range(0, 3));
                1: d = 16'h7FFF - 16'($urandom_range(0, 3));
                2: d = 16'($urandom_range(0, 3)) - 16'd2;
                3: d = 16'h0600 + 16'($urandom_range(0, 4)) - 16'd2;
                default: d = 16'($urandom);
            endcase
            apply(b, d);
            exp = ref_relu(b, d);
            checks++;
            if (dn_data !== exp) begin
                errors++;
                $display("FAIL random[%0d] byp=%0d in=%h: got %h want %h", i, b, d, dn_data, exp);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_negative();
        test_bypass();
        test_ramp();
        test_extremes();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
